bram_stream_mc: RTL and testbench

Instruction-driven, multi-bank BRAM with AXI-Stream ports; the parametrised successor of the two-bank 128-bit stream BRAM. Each 64-bit instruction selects read or write, a start word address and a beat count. The block then sinks write beats into the banks, with byte enables, or streams read beats out under full backpressure. It sits between the DMA stream fabric and the compute array as on-chip scratch storage.

---
 rtl/bram_stream_pkg.sv | 15 +
 rtl/bram_stream_bank.sv | 32 +++
 rtl/bram_stream_mc.sv | 180 ++++++++++++++++++
 tb/tb_bram_stream_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg: shared opcodes, instruction field offsets, FSM states and address sizing
package bram_stream_pkg;

    localparam logic OP_RD   = 1'b0;
    localparam logic OP_WR   = 1'b1;
    localparam int   OP_BIT  = 63;
    localparam int   LEN_LSB = 0;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

    function automatic int calc_addr_w(input int nbank, input int depth);
        return $clog2(nbank * depth);
    endfunction

endpackage

// File: rtl/bram_stream_bank.sv
// bram_stream_bank: single-port bank with byte write enables and an RD_LAT-stage registered read
module bram_stream_bank #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8192,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DATA_W-1:0] r_pipe [RD_LAT];

    // byte-granular write, committed on the clock edge
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++)
            if (i_we && i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end

    // read pipeline: array output register followed by RD_LAT-1 extra stages
    always_ff @(posedge clk) begin
        r_pipe[0] <= r_mem[i_addr];
        for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end

    assign o_rdata = r_pipe[RD_LAT-1];

endmodule

// File: rtl/bram_stream_mc.sv
// bram_stream_mc: instruction-driven multi-bank BRAM with stream ports; BRAM_STREAM_TLAST_CHK_EN enables tlast checking
module bram_stream_mc
    import bram_stream_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int NBANK      = 2,
    parameter int BANK_DEPTH = 8192,
    parameter int LEN_W      = 13,
    parameter int RD_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         s_instruct_tdata,
    input  logic                s_instruct_tvalid,
    output logic                s_instruct_tready,
    input  logic [DATA_W-1:0]   s_in_tdata,
    input  logic [DATA_W/8-1:0] s_in_tkeep,
    input  logic                s_in_tvalid,
    output logic                s_in_tready,
    input  logic                s_in_tlast,
    output logic [DATA_W-1:0]   m_out_tdata,
    output logic [DATA_W/8-1:0] m_out_tkeep,
    output logic                m_out_tvalid,
    input  logic                m_out_tready,
    output logic                m_out_tlast,
    output logic                busy,
    output logic                err
);

    localparam int ADDR_W     = calc_addr_w(NBANK, BANK_DEPTH);
    localparam int BA_W       = $clog2(BANK_DEPTH);
    localparam int BS_W       = $clog2(NBANK);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [RD_LAT-1:0] LAST_STAGE = RD_LAT'(1) << (RD_LAT - 1);

    state_t              r_state, w_state_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic [RD_LAT-1:0]   r_vld;
    logic [BS_W-1:0]     r_bsel [RD_LAT];
    logic                r_lst  [RD_LAT];
    logic [DATA_W-1:0]   r_fifo_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_l;
    logic [PTR_W-1:0]    r_wp, r_rp;
    logic [CNT_W-1:0]    r_fcnt;
    logic                r_err;
    logic [DATA_W-1:0]   w_bank_rd [NBANK];

    logic              w_ins_op;
    logic [ADDR_W-1:0] w_ins_addr;
    logic [LEN_W-1:0]  w_ins_len;
    logic              w_ins_hs, w_wr_hs, w_cnt_last, w_wr_end, w_err_set;
    logic              w_credit, w_issue, w_push, w_pop;
    logic [CNT_W-1:0]  w_fcnt_n;
    logic              w_unused;

    assign w_ins_op   = s_instruct_tdata[OP_BIT];
    assign w_ins_addr = s_instruct_tdata[LEN_LSB+LEN_W +: ADDR_W];
    assign w_ins_len  = s_instruct_tdata[LEN_LSB +: LEN_W];
    assign w_unused   = &{1'b0, s_instruct_tdata, s_in_tlast};

    assign w_ins_hs   = s_instruct_tvalid && s_instruct_tready;
    assign w_wr_hs    = s_in_tvalid && s_in_tready;
    assign w_cnt_last = r_cnt == LEN_W'(1);
    assign w_credit   = (32'(r_fcnt) + $countones(r_vld)) < FIFO_DEPTH;
    assign w_issue    = (r_state == S_RD) && w_credit;
    assign w_push     = r_vld[RD_LAT-1];
    assign w_pop      = m_out_tvalid && m_out_tready;
    assign w_fcnt_n   = r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);

`ifdef BRAM_STREAM_TLAST_CHK_EN
    assign w_wr_end  = w_cnt_last || s_in_tlast;
    assign w_err_set = w_wr_hs && (w_cnt_last != s_in_tlast);
`else
    assign w_wr_end  = w_cnt_last;
    assign w_err_set = 1'b0;
`endif

    // one bank per slice of the address space; the top address bits pick the bank
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        bram_stream_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH), .RD_LAT(RD_LAT)) u_bank (
            .clk     (clk),
            .i_we    (w_wr_hs && (r_addr[ADDR_W-1 -: BS_W] == BS_W'(b))),
            .i_be    (s_in_tkeep),
            .i_addr  (r_addr[BA_W-1:0]),
            .i_wdata (s_in_tdata),
            .o_rdata (w_bank_rd[b])
        );
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // next state and handshake outputs; DRAIN leaves once nothing will be left after this edge
    always_comb begin
        w_state_n         = r_state;
        s_instruct_tready = (r_state == S_IDLE) && !rst;
        s_in_tready       = r_state == S_WR;
        case (r_state)
            S_IDLE:  if (w_ins_hs && w_ins_len != '0) w_state_n = (w_ins_op == OP_WR) ? S_WR : S_RD;
            S_WR:    if (w_wr_hs && w_wr_end) w_state_n = S_IDLE;
            S_RD:    if (w_issue && w_cnt_last) w_state_n = S_DRAIN;
            S_DRAIN: if (w_fcnt_n == '0 && (r_vld & ~LAST_STAGE) == '0) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // address/beat counter, loaded by an instruction and stepped per write beat or read issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (w_ins_hs) begin
            r_addr <= w_ins_addr;
            r_cnt  <= w_ins_len;
        end else if (w_wr_hs || w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // in-flight read valid pipeline, cleared on reset so pending reads are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld <= '0;
        else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // bank select and last flag travel alongside the read to steer the returning word
    always_ff @(posedge clk) begin
        r_bsel[0] <= r_addr[ADDR_W-1 -: BS_W];
        r_lst[0]  <= w_cnt_last;
        for (int i = 1; i < RD_LAT; i++) begin
            r_bsel[i] <= r_bsel[i-1];
            r_lst[i]  <= r_lst[i-1];
        end
    end

    // output FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wp + 1'b1;
            if (w_pop)  r_rp <= (r_rp == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rp + 1'b1;
            r_fcnt <= w_fcnt_n;
        end
    end

    // output FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_d[r_wp] <= w_bank_rd[r_bsel[RD_LAT-1]];
            r_fifo_l[r_wp] <= r_lst[RD_LAT-1];
        end
    end

    // sticky tlast-mismatch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    assign m_out_tvalid = r_fcnt != '0;
    assign m_out_tdata  = r_fifo_d[r_rp];
    assign m_out_tlast  = m_out_tvalid && r_fifo_l[r_rp];
    assign m_out_tkeep  = '1;
    assign busy         = (r_state != S_IDLE) || (r_fcnt != '0);
    assign err          = r_err;

endmodule

// File: tb/tb_bram_stream_mc.sv
// tb_bram_stream_mc: randomized scoreboard bench for bram_stream_mc against an array memory model
module tb_bram_stream_mc;

    localparam int DATA_W = 128;
    localparam int KW     = DATA_W / 8;
    localparam int LEN_W  = 13;
    localparam int RD_LAT = 2;
    localparam int AW     = 14;
    localparam int SIZE   = 1 << AW;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [63:0]       s_instruct_tdata = '0;
    logic              s_instruct_tvalid = 1'b0;
    logic              s_instruct_tready;
    logic [DATA_W-1:0] s_in_tdata = '0;
    logic [KW-1:0]     s_in_tkeep = '0;
    logic              s_in_tvalid = 1'b0;
    logic              s_in_tready;
    logic              s_in_tlast = 1'b0;
    logic [DATA_W-1:0] m_out_tdata;
    logic [KW-1:0]     m_out_tkeep;
    logic              m_out_tvalid;
    logic              m_out_tready = 1'b1;
    logic              m_out_tlast;
    logic              busy;
    logic              err;

    logic [DATA_W-1:0] mem_m [SIZE];
    logic [DATA_W-1:0] wdat  [64];
    exp_t              q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                hs_cyc = 0;
    int                rdy_mode = 0;
    bit                chk_rdy_next = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_d;
    logic              prev_l;

    bram_stream_mc dut (
        .clk               (clk),
        .rst               (rst),
        .s_instruct_tdata  (s_instruct_tdata),
        .s_instruct_tvalid (s_instruct_tvalid),
        .s_instruct_tready (s_instruct_tready),
        .s_in_tdata        (s_in_tdata),
        .s_in_tkeep        (s_in_tkeep),
        .s_in_tvalid       (s_in_tvalid),
        .s_in_tready       (s_in_tready),
        .s_in_tlast        (s_in_tlast),
        .m_out_tdata       (m_out_tdata),
        .m_out_tkeep       (m_out_tkeep),
        .m_out_tvalid      (m_out_tvalid),
        .m_out_tready      (m_out_tready),
        .m_out_tlast       (m_out_tlast),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
    endtask

    // caller is at a negedge; returns at the negedge after the handshake
    task automatic send_instr(input bit op, input int addr, input int len);
        int n = 0;
        s_instruct_tdata        = '0;
        s_instruct_tdata[63]    = op;
        s_instruct_tdata[26:13] = 14'(addr);
        s_instruct_tdata[12:0]  = 13'(len);
        s_instruct_tvalid       = 1'b1;
        while (!s_instruct_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout("instr_handshake");
        hs_cyc = cyc;
        if (!op)
            for (int k = 0; k < len; k++)
                q.push_back('{d: mem_m[(addr + k) % SIZE], l: (k == len - 1)});
        @(negedge clk);
        s_instruct_tvalid = 1'b0;
    endtask

    task automatic wr_beats(input int addr, input int n, input logic [KW-1:0] keep, input int tlast_at);
        int m;
        int a;
        for (int k = 0; k < n; k++) begin
            s_in_tvalid = 1'b1;
            s_in_tdata  = wdat[k];
            s_in_tkeep  = keep;
            s_in_tlast  = (k == tlast_at);
            if (k == 0) chk1("wr_ready_after_instr", s_in_tready, 1'b1);
            m = 0;
            while (!s_in_tready && m < 100) begin
                @(negedge clk);
                m++;
            end
            if (m >= 100) timeout("wr_beat");
            a = (addr + k) % SIZE;
            for (int b = 0; b < KW; b++)
                if (keep[b]) mem_m[a][b*8 +: 8] = wdat[k][b*8 +: 8];
            @(negedge clk);
        end
        s_in_tvalid = 1'b0;
        s_in_tlast  = 1'b0;
        chk1("wr_done_instr_ready", s_instruct_tready, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) timeout("wait_idle");
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) wdat[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // monitor: drives m_out_tready, pops the scoreboard on each output handshake, checks stall stability
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall   = 0;
                chk_rdy_next = 0;
            end else begin
                if (prev_stall) begin
                    chk1("stall_valid_held", m_out_tvalid, 1'b1);
                    chkw("stall_data_held", m_out_tdata, prev_d);
                    chk1("stall_last_held", m_out_tlast, prev_l);
                end
                if (chk_rdy_next) begin
                    chk1("rd_done_instr_ready", s_instruct_tready, 1'b1);
                    chk_rdy_next = 0;
                end
                m_out_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (m_out_tvalid && m_out_tready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h with no beat expected", m_out_tdata);
                    end else begin
                        e = q.pop_front();
                        chkw("rd_data", m_out_tdata, e.d);
                        chk1("rd_last", m_out_tlast, e.l);
                        chkw("rd_keep", 128'(m_out_tkeep), 128'({KW{1'b1}}));
                    end
                    if (m_out_tlast) chk_rdy_next = 1;
                end
                prev_stall = m_out_tvalid && !m_out_tready;
                prev_d     = m_out_tdata;
                prev_l     = m_out_tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int n;
        repeat (3) @(negedge clk);
        chk1("rst_instr_ready", s_instruct_tready, 1'b0);
        chk1("rst_in_ready", s_in_tready, 1'b0);
        chk1("rst_out_valid", m_out_tvalid, 1'b0);
        chk1("rst_out_last", m_out_tlast, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("instr_ready_after_rst", s_instruct_tready, 1'b1);

        // sequential write then read with first-beat latency
        for (int k = 0; k < 4; k++) wdat[k] = DATA_W'(k);
        send_instr(1, 'h10, 4);
        wr_beats('h10, 4, '1, 3);
        send_instr(0, 'h10, 4);
        chk1("busy_during_rd", busy, 1'b1);
        n = 0;
        while (!m_out_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkw("rd_first_latency", 128'(cyc - hs_cyc), 128'(RD_LAT + 2));
        wait_idle();

        // partial byte write at the top of bank 0
        wdat[0] = {KW{8'h55}};
        send_instr(1, 'h1FFF, 1);
        wr_beats('h1FFF, 1, '1, 0);
        wdat[0] = {KW{8'hAA}};
        send_instr(1, 'h1FFF, 1);
        wr_beats('h1FFF, 1, 16'h000F, 0);
        send_instr(0, 'h1FFF, 1);
        wait_idle();

        // wrap across the top of the array
        fill_rand(8);
        send_instr(1, 'h3FFE, 8);
        wr_beats('h3FFE, 8, '1, 7);
        send_instr(0, 'h3FFE, 8);
        wait_idle();

        // 16-beat read under random backpressure, then random traffic
        fill_rand(64);
        send_instr(1, 'h100, 64);
        wr_beats('h100, 64, '1, 63);
        rdy_mode = 1;
        send_instr(0, 'h100, 16);
        wait_idle();
        for (int it = 0; it < 24; it++) begin
            int a = 'h100 + $urandom_range(0, 48);
            int l = $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 1) begin
                fill_rand(l);
                send_instr(1, a, l);
                wr_beats(a, l, KW'({$urandom, $urandom}), l - 1);
            end else begin
                send_instr(0, a, l);
                wait_idle();
            end
        end
        rdy_mode = 0;
        wait_idle();

        // zero-length read followed immediately by a one-beat write
        send_instr(0, 'h20, 0);
        t0 = hs_cyc;
        fill_rand(1);
        send_instr(1, 'h20, 1);
        chkw("len0_back_to_back", 128'(hs_cyc - t0), 128'(1));
        wr_beats('h20, 1, '1, 0);
        send_instr(0, 'h20, 1);
        wait_idle();

        // early tlast on a 4-beat write
        fill_rand(4);
        send_instr(1, 'h40, 4);
        wr_beats('h40, 4, '1, 3);
        fill_rand(4);
        send_instr(1, 'h40, 4);
`ifdef BRAM_STREAM_TLAST_CHK_EN
        wr_beats('h40, 2, '1, 1);
        chk1("early_tlast_err", err, 1'b1);
        chk1("early_tlast_no_more_beats", s_in_tready, 1'b0);
`else
        wr_beats('h40, 4, '1, 1);
        chk1("tlast_ignored_err", err, 1'b0);
`endif
        send_instr(0, 'h40, 4);
        wait_idle();

        // reset in the middle of a stalled read; memory contents survive
        rdy_mode = 2;
        send_instr(0, 'h100, 16);
        repeat (8) @(negedge clk);
        chk1("stalled_out_valid", m_out_tvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("midrst_out_valid", m_out_tvalid, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        send_instr(0, 'h10, 4);
        n = 0;
        while (!m_out_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkw("rd_latency_after_rst", 128'(cyc - hs_cyc), 128'(RD_LAT + 2));
        wait_idle();
        repeat (2) @(negedge clk);
        chk1("final_busy", busy, 1'b0);
        chk1("final_out_valid", m_out_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
